pipe_mem_ctrl: RTL

- Sequences the data-memory access of the MEM stage in the five-stage pipeline.
- Sits between the EX/MEM and MEM/WB pipeline registers.
- Drives a variable-latency req/ack data-memory port, freezes the upstream stages until the access completes, and injects a bubble into MEM/WB while waiting.
- Keeps a saturating count of stall cycles for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_mem_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones once reached, cleared by async active-low reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_mem_ctrl.sv
// MEM-stage data-memory sequencer: req/ack port, pipeline stall, MEM/WB bubble, stall counter.
// Define STALL_TIMEOUT_EN to abort WAIT after TIMEOUT cycles and raise a sticky err.
module pipe_mem_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             mvalid,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mwmem,
  input  logic [31:0]      malu,
  input  logic [31:0]      mb,
  output logic             dreq,
  output logic             dwe,
  output logic [31:0]      daddr,
  output logic [31:0]      dwdata,
  input  logic             dack,
  input  logic [31:0]      drdata,
  output logic             stall,
  output logic             mwreg_q,
  output logic [31:0]      mmo,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("pipe_mem_ctrl: TIMEOUT must be at least 1");
  end

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_op;
  logic        req;
  logic        tmo;

  assign mem_op = mvalid & (mm2reg | mwmem);

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          req = 1'b1;
          if (dack) begin
            rdata_d = drdata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dack) begin
          rdata_d = drdata;
          state_d = DONE;
        end else if (tmo) begin
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef STALL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;

  // tcnt counts completed ackless WAIT cycles; the TIMEOUT-th one aborts.
  assign tmo    = (state_q == WAIT) && !dack && (tcnt_q == TW'(TIMEOUT - 1));
  assign tcnt_d = (state_q == WAIT) ? tcnt_q + 1'b1 : '0;
  assign err_d  = err_q | tmo;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Request-side outputs are forced low for the whole reset interval.
  assign dreq    = resetn & req;
  assign stall   = dreq;
  assign dwe     = mwmem & dreq;
  assign daddr   = malu;
  assign dwdata  = mb;
  assign mwreg_q = resetn & mvalid & mwreg & ~stall;
  assign mmo     = rdata_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clock  (clock),
    .resetn (resetn),
    .en     (stall),
    .count  (stall_cnt)
  );

endmodule
